wishbone_rr_arbiter: RTL and testbench

- Shares one pipelined Wishbone B4 target port between NumInitiators initiators using round-robin arbitration.
- Grant is held for the owner's whole bus cycle (CYC asserted); no interleaving within a cycle.
- Tracks the owner's outstanding transfers and caps them, so a downstream skid buffer or target is never over-committed.
- Sits between initiator-side skid buffers and the shared target or interconnect.

---
 rtl/wishbone_rr_arbiter.sv | 163 ++++++++++++++++
 tb/tb_wishbone_rr_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_rr_arbiter.sv
// Round-robin arbiter sharing one pipelined Wishbone B4 target between NumInitiators initiators,
// with an outstanding-transfer cap. Optional watchdog: define WB_ARB_TIMEOUT_EN.
module wishbone_rr_arbiter #(
    parameter int NumInitiators  = 2,
    parameter int AddressWidth   = 16,
    parameter int DataWidth      = 8,
    parameter int Granularity    = 8,
    parameter int MaxOutstanding = 4,
    parameter int TimeoutCycles  = 256
) (
    input  logic                                 CLK_I,
    input  logic                                 RST_I,
    input  logic [NumInitiators-1:0]             I_CYC_I,
    input  logic [NumInitiators-1:0]             I_STB_I,
    input  logic [NumInitiators-1:0]             I_WE_I,
    input  logic [NumInitiators*AddressWidth-1:0] I_ADDR_I,
    input  logic [NumInitiators*DataWidth-1:0]   I_DAT_I,
    input  logic [NumInitiators*(DataWidth/Granularity)-1:0] I_SEL_I,
    output logic [DataWidth-1:0]                 I_DAT_O,
    output logic [NumInitiators-1:0]             I_ACK_O,
    output logic [NumInitiators-1:0]             I_ERR_O,
    output logic [NumInitiators-1:0]             I_STALL_O,
    output logic                                 CYC_O,
    output logic                                 STB_O,
    output logic                                 WE_O,
    output logic [AddressWidth-1:0]              ADDR_O,
    output logic [DataWidth-1:0]                 DAT_O,
    output logic [DataWidth/Granularity-1:0]     SEL_O,
    input  logic [DataWidth-1:0]                 DAT_I,
    input  logic                                 ACK_I,
    input  logic                                 ERR_I,
    input  logic                                 STALL_I,
    output logic [NumInitiators-1:0]             GNT_O
);

    localparam int SelWidth = DataWidth / Granularity;
    localparam int IdxW     = (NumInitiators > 1) ? $clog2(NumInitiators) : 1;
    localparam int CntW     = $clog2(MaxOutstanding + 1);

    typedef enum logic {S_IDLE, S_OWNED} state_t;

    state_t                   r_state, w_state_nxt;
    logic [IdxW-1:0]          r_owner, r_last, w_pick, w_cand;
    logic                     w_found;
    logic [CntW-1:0]          r_count;
    logic                     w_full, w_accept, w_resp, w_release, w_timeout, w_cyc;
    logic [NumInitiators-1:0] w_req, w_owner_oh;

    assign w_full     = (r_count == CntW'(MaxOutstanding));
    assign w_accept   = STB_O & ~STALL_I;
    assign w_resp     = ACK_I | ERR_I;
    assign w_owner_oh = {{(NumInitiators-1){1'b0}}, 1'b1} << r_owner;
    assign w_release  = (r_state == S_OWNED) && (!I_CYC_I[r_owner] || w_timeout);
    assign I_DAT_O    = DAT_I;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int WdW = $clog2(TimeoutCycles + 1);
    logic [WdW-1:0]           r_wdog;
    logic [NumInitiators-1:0] r_mask;

    // A timed-out owner sits out one arbitration round, or until it drops CYC.
    assign w_timeout = (r_state == S_OWNED) && (r_count != '0) && !w_resp
                       && (r_wdog == WdW'(TimeoutCycles - 1));
    assign w_req     = I_CYC_I & ~r_mask;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_wdog <= '0;
            r_mask <= '0;
        end else begin
            if (r_state != S_OWNED || r_count == '0 || w_resp || w_timeout)
                r_wdog <= '0;
            else
                r_wdog <= r_wdog + WdW'(1);

            if (w_timeout)
                r_mask <= w_owner_oh;
            else if (r_state == S_IDLE && w_found)
                r_mask <= '0;
            else
                r_mask <= r_mask & I_CYC_I;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign w_req     = I_CYC_I;
`endif

    // Cyclic priority search starting just after the last owner.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_last;
        w_cand  = r_last;
        for (int i = 1; i <= NumInitiators; i++) begin
            w_cand = IdxW'((int'(r_last) + i) % NumInitiators);
            if (!w_found && w_req[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_found)   w_state_nxt = S_OWNED;
            S_OWNED: if (w_release) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: every output gets a default before the state-dependent overrides, so no latch is inferred.
    always_comb begin
        w_cyc     = 1'b0;
        CYC_O     = 1'b0;
        STB_O     = 1'b0;
        WE_O      = 1'b0;
        ADDR_O    = '0;
        DAT_O     = '0;
        SEL_O     = '0;
        I_ACK_O   = '0;
        I_ERR_O   = '0;
        I_STALL_O = '1;
        GNT_O     = '0;
        if (r_state == S_OWNED) begin
            w_cyc              = I_CYC_I[r_owner] & ~w_timeout;
            GNT_O              = w_owner_oh;
            CYC_O              = w_cyc;
            STB_O              = I_STB_I[r_owner] & w_cyc & ~w_full;
            WE_O               = I_WE_I[r_owner];
            ADDR_O             = I_ADDR_I[r_owner*AddressWidth +: AddressWidth];
            DAT_O              = I_DAT_I[r_owner*DataWidth +: DataWidth];
            SEL_O              = I_SEL_I[r_owner*SelWidth +: SelWidth];
            I_STALL_O[r_owner] = STALL_I | w_full | w_timeout;
            I_ACK_O[r_owner]   = ACK_I;
            I_ERR_O[r_owner]   = ERR_I | w_timeout;
        end
    end

    // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_state <= S_IDLE;
            r_owner <= '0;
            r_last  <= IdxW'(NumInitiators - 1);
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE) begin
                r_count <= '0;
                if (w_found) r_owner <= w_pick;
            end else if (w_release) begin
                r_last  <= r_owner;
                r_count <= '0;
            end else if (w_accept && !w_resp) begin
                r_count <= r_count + CntW'(1);
            end else if (w_resp && !w_accept && r_count != '0) begin
                r_count <= r_count - CntW'(1);
            end
        end
    end

endmodule

// File: tb/tb_wishbone_rr_arbiter.sv
// Self-checking bench for wishbone_rr_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level reference model of the arbitration rules.
module tb_wishbone_rr_arbiter;

    localparam int N = 2, AW = 16, DW = 8, SW = 1, MAXO = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]    cyc_i, stb_i, we_i;
    logic [N*AW-1:0] addr_i;
    logic [N*DW-1:0] dat_i;
    logic [N*SW-1:0] sel_i;
    logic [DW-1:0]   i_dat_o, dat_o, t_dat;
    logic [N-1:0]    ack_o, err_o, stall_o, gnt;
    logic            cyc_o, stb_o, we_o, t_ack, t_err, t_stall;
    logic [AW-1:0]   addr_o;
    logic [SW-1:0]   sel_o;

    int n_pass = 0, n_total = 0;

    wishbone_rr_arbiter #(
        .NumInitiators(N), .AddressWidth(AW), .DataWidth(DW), .Granularity(8),
        .MaxOutstanding(MAXO), .TimeoutCycles(256)
    ) dut (
        .CLK_I(clk), .RST_I(rst),
        .I_CYC_I(cyc_i), .I_STB_I(stb_i), .I_WE_I(we_i), .I_ADDR_I(addr_i),
        .I_DAT_I(dat_i), .I_SEL_I(sel_i), .I_DAT_O(i_dat_o), .I_ACK_O(ack_o),
        .I_ERR_O(err_o), .I_STALL_O(stall_o), .CYC_O(cyc_o), .STB_O(stb_o),
        .WE_O(we_o), .ADDR_O(addr_o), .DAT_O(dat_o), .SEL_O(sel_o),
        .DAT_I(t_dat), .ACK_I(t_ack), .ERR_I(t_err), .STALL_I(t_stall), .GNT_O(gnt)
    );

    task automatic clear_inputs();
        cyc_i = '0; stb_i = '0; we_i = '0; addr_i = '0; dat_i = '0; sel_i = '0;
        t_dat = '0; t_ack = 1'b0; t_err = 1'b0; t_stall = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        cyc_i = 2'b11;
        #2;
        n_total++;
        if ({gnt, cyc_o, stb_o, ack_o, err_o, stall_o} !== {2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b11})
            $display("FAIL reset_outputs: got gnt=%b cyc=%b stb=%b ack=%b err=%b stall=%b want 00 0 0 00 00 11",
                     gnt, cyc_o, stb_o, ack_o, err_o, stall_o);
        else n_pass++;
        do_reset();
        // Mid-cycle reset: outputs drop at once and initiator 0 wins again afterwards.
        cyc_i = 2'b01;
        tick();
        tick();
        rst = 1'b1;
        #2;
        n_total++;
        if ({gnt, cyc_o} !== 3'b000) $display("FAIL midcycle_reset: got gnt=%b cyc=%b want 00 0", gnt, cyc_o);
        else n_pass++;
        tick();
        rst = 1'b0;
        cyc_i = 2'b11;
        tick();
        n_total++;
        if (gnt !== 2'b01) $display("FAIL reset_pointer: got gnt=%b want 01", gnt);
        else n_pass++;
        clear_inputs();
    endtask

    task automatic test_single_read();
        do_reset();
        cyc_i = 2'b01; stb_i = 2'b01; addr_i[AW-1:0] = 16'h1234;
        @(negedge clk);
        n_total++;
        if (gnt !== 2'b00) $display("FAIL arb_latency: got gnt=%b want 00", gnt);
        else n_pass++;
        tick();
        @(negedge clk);
        n_total++;
        if ({gnt, cyc_o, stb_o, addr_o} !== {2'b01, 1'b1, 1'b1, 16'h1234})
            $display("FAIL read_issue: got gnt=%b cyc=%b stb=%b addr=%h want 01 1 1 1234", gnt, cyc_o, stb_o, addr_o);
        else n_pass++;
        tick();
        stb_i = '0;
        tick();
        t_ack = 1'b1; t_dat = 8'hA5;
        @(negedge clk);
        n_total++;
        if ({ack_o, i_dat_o} !== {2'b01, 8'hA5}) $display("FAIL read_ack: got ack=%b dat=%h want 01 a5", ack_o, i_dat_o);
        else n_pass++;
        tick();
        t_ack = 1'b0; cyc_i = '0;
        @(negedge clk);
        n_total++;
        if (cyc_o !== 1'b0) $display("FAIL release_comb: got cyc_o=%b want 0", cyc_o);
        else n_pass++;
        tick();
        @(negedge clk);
        n_total++;
        if (gnt !== 2'b00) $display("FAIL release_gnt: got gnt=%b want 00", gnt);
        else n_pass++;
        clear_inputs();
    endtask

    task automatic test_fairness();
        logic [N-1:0] exp_gnt;
        int g, waited;
        do_reset();
        cyc_i = 2'b11;
        for (int r = 0; r < 6; r++) begin
            waited = 0;
            while (gnt == '0 && waited < 4) begin tick(); waited++; end
            g = r % N;
            exp_gnt = 2'b01 << g;
            n_total++;
            if (gnt !== exp_gnt) $display("FAIL fairness_round%0d: got gnt=%b want %b", r, gnt, exp_gnt);
            else n_pass++;
            stb_i[g] = 1'b1;
            tick();
            stb_i = '0; t_ack = 1'b1;
            tick();
            t_ack = 1'b0; cyc_i[g] = 1'b0;
            tick();
            cyc_i = 2'b11;
        end
        clear_inputs();
    endtask

    task automatic test_outstanding_cap();
        int acc;
        do_reset();
        cyc_i = 2'b01;
        tick();
        stb_i = 2'b01;
        acc = 0;
        repeat (6) begin
            @(negedge clk);
            if (stb_o && !t_stall) acc++;
            tick();
        end
        n_total++;
        if (acc != MAXO) $display("FAIL cap_accepted: got %0d want %0d", acc, MAXO);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({stb_o, stall_o[0]} !== 2'b01) $display("FAIL cap_full: got stb=%b stall0=%b want 0 1", stb_o, stall_o[0]);
        else n_pass++;
        tick();
        t_ack = 1'b1;
        @(negedge clk);
        n_total++;
        if (stb_o !== 1'b0) $display("FAIL cap_ack_cycle: got stb=%b want 0", stb_o);
        else n_pass++;
        tick();
        t_ack = 1'b0;
        @(negedge clk);
        n_total++;
        if ({stb_o, stall_o[0]} !== 2'b10) $display("FAIL cap_fifth: got stb=%b stall0=%b want 1 0", stb_o, stall_o[0]);
        else n_pass++;
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_same_cycle_and_late();
        int acc;
        do_reset();
        cyc_i = 2'b01;
        tick();
        stb_i = 2'b01;
        tick();
        tick();
        t_ack = 1'b1;
        @(negedge clk);
        n_total++;
        if (stb_o !== 1'b1) $display("FAIL same_cycle_stb: got stb=%b want 1", stb_o);
        else n_pass++;
        tick();
        t_ack = 1'b0;
        acc = 0;
        repeat (4) begin
            @(negedge clk);
            if (stb_o && !t_stall) acc++;
            tick();
        end
        n_total++;
        if (acc != 2) $display("FAIL same_cycle_count: got %0d more accepted want 2", acc);
        else n_pass++;
        stb_i = '0; cyc_i = '0;
        tick();
        t_ack = 1'b1;
        @(negedge clk);
        n_total++;
        if ({ack_o, gnt} !== 4'b0000) $display("FAIL late_ack: got ack=%b gnt=%b want 00 00", ack_o, gnt);
        else n_pass++;
        tick();
        t_ack = 1'b0; cyc_i = 2'b10; stb_i = 2'b10;
        tick();
        acc = 0;
        repeat (6) begin
            @(negedge clk);
            if (stb_o && !t_stall) acc++;
            tick();
        end
        n_total++;
        if (acc != MAXO) $display("FAIL count_cleared: got %0d accepted want %0d", acc, MAXO);
        else n_pass++;
        clear_inputs();
        tick();
    endtask

    task automatic test_nonowner_err();
        do_reset();
        cyc_i = 2'b01;
        addr_i = {16'h5555, 16'hAAAA};
        tick();
        cyc_i = 2'b11; stb_i = 2'b11; we_i = 2'b10;
        @(negedge clk);
        n_total++;
        if ({gnt, stall_o, addr_o, we_o} !== {2'b01, 2'b10, 16'hAAAA, 1'b0})
            $display("FAIL nonowner_stall: got gnt=%b stall=%b addr=%h we=%b want 01 10 aaaa 0", gnt, stall_o, addr_o, we_o);
        else n_pass++;
        tick();
        stb_i = '0; t_err = 1'b1;
        @(negedge clk);
        n_total++;
        if ({err_o, ack_o} !== 4'b0100) $display("FAIL err_route: got err=%b ack=%b want 01 00", err_o, ack_o);
        else n_pass++;
        tick();
        t_err = 1'b0; cyc_i = 2'b10;
        tick();
        tick();
        n_total++;
        if (gnt !== 2'b10) $display("FAIL handover: got gnt=%b want 10", gnt);
        else n_pass++;
        clear_inputs();
        tick();
    endtask

    // Reference model: owner index (-1 when nobody holds the bus), last owner, outstanding count.
    task automatic test_random();
        int m_owner, m_last, m_cnt, g, k;
        logic full, acc;
        logic [N-1:0] e_gnt, e_stall, e_ack, e_err;
        logic e_cyc, e_stb, e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_dat;
        logic [SW-1:0] e_sel;
        do_reset();
        m_owner = -1; m_last = N - 1; m_cnt = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(5) == 0) cyc_i[i] = ~cyc_i[i];
            stb_i   = N'($urandom) & cyc_i;
            we_i    = N'($urandom);
            addr_i  = {$urandom, $urandom};
            dat_i   = (N*DW)'($urandom);
            sel_i   = (N*SW)'($urandom);
            t_dat   = DW'($urandom);
            t_ack   = ($urandom_range(3) == 0);
            t_err   = ($urandom_range(9) == 0);
            t_stall = ($urandom_range(2) == 0);
            @(negedge clk);
            e_gnt = '0; e_stall = '1; e_ack = '0; e_err = '0;
            e_cyc = 0; e_stb = 0; e_we = 0; e_addr = '0; e_dat = '0; e_sel = '0;
            full = (m_cnt == MAXO);
            if (m_owner >= 0) begin
                g = m_owner;
                e_gnt[g] = 1'b1;
                e_cyc = cyc_i[g];
                e_stb = stb_i[g] & cyc_i[g] & ~full;
                e_we = we_i[g];
                e_addr = addr_i[g*AW +: AW];
                e_dat = dat_i[g*DW +: DW];
                e_sel = sel_i[g*SW +: SW];
                e_stall[g] = t_stall | full;
                e_ack[g] = t_ack;
                e_err[g] = t_err;
            end
            n_total++;
            if ({gnt, cyc_o, stb_o, stall_o, ack_o, err_o, i_dat_o} !== {e_gnt, e_cyc, e_stb, e_stall, e_ack, e_err, t_dat})
                $display("FAIL rand_ctrl c%0d: got gnt=%b cyc=%b stb=%b stall=%b ack=%b err=%b dat=%h want %b %b %b %b %b %b %h",
                         c, gnt, cyc_o, stb_o, stall_o, ack_o, err_o, i_dat_o,
                         e_gnt, e_cyc, e_stb, e_stall, e_ack, e_err, t_dat);
            else n_pass++;
            n_total++;
            if ({we_o, addr_o, dat_o, sel_o} !== {e_we, e_addr, e_dat, e_sel})
                $display("FAIL rand_data c%0d: got we=%b addr=%h dat=%h sel=%b want %b %h %h %b",
                         c, we_o, addr_o, dat_o, sel_o, e_we, e_addr, e_dat, e_sel);
            else n_pass++;
            @(posedge clk);
            if (m_owner < 0) begin
                for (int i = 1; i <= N; i++) begin
                    k = (m_last + i) % N;
                    if (m_owner < 0 && cyc_i[k]) m_owner = k;
                end
                m_cnt = 0;
            end else if (!cyc_i[m_owner]) begin
                m_last = m_owner; m_owner = -1; m_cnt = 0;
            end else begin
                acc = e_stb & ~t_stall;
                if (acc && !(t_ack || t_err)) m_cnt++;
                else if (!acc && (t_ack || t_err) && m_cnt > 0) m_cnt--;
            end
            #1;
        end
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time budget");
        $fatal(1, "time budget exceeded");
    end

    initial begin
        test_reset();
        test_single_read();
        test_fairness();
        test_outstanding_cap();
        test_same_cycle_and_late();
        test_nonowner_err();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
